// File: rtl/uart_rx_if.sv
// uart_rx_if: groups the serial input and the byte-level outputs of uart_rx.
//   master modport : the receiver (samples rx, drives the byte-side outputs)
//   slave modport  : the line driver / byte consumer (drives rx, observes outputs)
// Signals:
//   rx         serial line, idle high
//   rx_data    last correctly framed byte
//   rx_valid   one-cycle pulse, rx_data updated
//   frame_err  one-cycle pulse, stop bit sampled low
//   busy       receiver is inside a frame
//   parity_err one-cycle pulse with rx_valid on bad even parity
//              (only present when UART_RX_PARITY_EN is defined)
interface uart_rx_if;
    logic       rx;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       frame_err;
    logic       busy;
`ifdef UART_RX_PARITY_EN
    logic       parity_err;
`endif

    modport master (
`ifdef UART_RX_PARITY_EN
        output parity_err,
`endif
        input  rx,
        output rx_data,
        output rx_valid,
        output frame_err,
        output busy
    );

    modport slave (
`ifdef UART_RX_PARITY_EN
        input  parity_err,
`endif
        output rx,
        input  rx_data,
        input  rx_valid,
        input  frame_err,
        input  busy
    );
endinterface

// File: rtl/uart_rx.sv
// uart_rx: 8N1 UART receiver.
//   Synchronises the asynchronous rx line through two flops, detects the
//   start bit, samples every bit at mid-bit and delivers each byte with a
//   one-cycle rx_valid strobe. A low stop bit gives a one-cycle frame_err and
//   the receiver then waits for the line to return high (break handling).
// Ports:
//   clk  system clock, rising edge
//   rst  synchronous, active-low reset
//   bus  uart_rx_if.master: rx in; rx_data, rx_valid, frame_err, busy out
// Build option:
//   UART_RX_PARITY_EN  adds an even-parity bit between data and stop and the
//                      parity_err output (pulses together with rx_valid).
module uart_rx #(
    parameter int CLK_FREQ  = 125000000,
    parameter int BAUD_RATE = 115200
) (
    input  logic      clk,
    input  logic      rst,
    uart_rx_if.master bus
);
    localparam int BIT_TIME = CLK_FREQ / BAUD_RATE;
    localparam int HALF_BIT = BIT_TIME / 2;
    localparam logic [15:0] BIT_LAST  = 16'(BIT_TIME - 1);
    localparam logic [15:0] HALF_LAST = 16'(HALF_BIT - 1);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
`ifdef UART_RX_PARITY_EN
        PARITY = 3'd3,
`endif
        STOP   = 3'd4,
        BREAK  = 3'd5
    } state_t;

`ifdef UART_RX_PARITY_EN
    // Even parity over data plus parity bit: any odd count of ones is an error.
    function automatic logic parity_fail(input logic [7:0] data, input logic par);
        return ^{data, par};
    endfunction
`endif

    logic        rx_meta_r;
    logic        rx_sync_r;
    logic        rx_s;

    state_t      state_r,      state_s;
    logic [15:0] clk_count_r,  clk_count_s;
    logic [2:0]  bit_index_r,  bit_index_s;
    logic [7:0]  shift_r,      shift_s;
    logic        valid_s;
    logic        ferr_s;

    logic [7:0]  rx_data_r;
    logic        rx_valid_r;
    logic        frame_err_r;
    logic        busy_r;

`ifdef UART_RX_PARITY_EN
    logic        parity_bit_r, parity_bit_s;
    logic        perr_s;
    logic        parity_err_r;
`endif

    // Two-flop synchroniser; both stages reset to the idle (high) line level.
    always_ff @(posedge clk) begin
        if (!rst) begin
            rx_meta_r <= 1'b1;
            rx_sync_r <= 1'b1;
        end else begin
            rx_meta_r <= bus.rx;
            rx_sync_r <= rx_meta_r;
        end
    end

    assign rx_s = rx_sync_r;

    // Next-state, counters and the one-cycle decision strobes.
    always_comb begin
        state_s      = state_r;
        clk_count_s  = clk_count_r;
        bit_index_s  = bit_index_r;
        shift_s      = shift_r;
        valid_s      = 1'b0;
        ferr_s       = 1'b0;
`ifdef UART_RX_PARITY_EN
        parity_bit_s = parity_bit_r;
        perr_s       = 1'b0;
`endif
        case (state_r)
            IDLE: begin
                clk_count_s = 16'd0;
                if (rx_s == 1'b0) begin
                    state_s = START;
                end else begin
                    state_s = IDLE;
                end
            end
            START: begin
                // Mid-start-bit check: a line already high again was a glitch.
                if (clk_count_r == HALF_LAST) begin
                    clk_count_s = 16'd0;
                    bit_index_s = 3'd0;
                    if (rx_s == 1'b0) begin
                        state_s = DATA;
                    end else begin
                        state_s = IDLE;
                    end
                end else begin
                    clk_count_s = clk_count_r + 16'd1;
                end
            end
            DATA: begin
                if (clk_count_r == BIT_LAST) begin
                    clk_count_s = 16'd0;
                    // LSB arrives first, so shifting right leaves it in bit 0.
                    shift_s = {rx_s, shift_r[7:1]};
                    if (bit_index_r == 3'd7) begin
                        bit_index_s = 3'd0;
`ifdef UART_RX_PARITY_EN
                        state_s = PARITY;
`else
                        state_s = STOP;
`endif
                    end else begin
                        bit_index_s = bit_index_r + 3'd1;
                    end
                end else begin
                    clk_count_s = clk_count_r + 16'd1;
                end
            end
`ifdef UART_RX_PARITY_EN
            PARITY: begin
                if (clk_count_r == BIT_LAST) begin
                    clk_count_s  = 16'd0;
                    parity_bit_s = rx_s;
                    state_s      = STOP;
                end else begin
                    clk_count_s = clk_count_r + 16'd1;
                end
            end
`endif
            STOP: begin
                // Deciding at mid-stop-bit lets a start edge right after the
                // stop bit be seen from IDLE.
                if (clk_count_r == BIT_LAST) begin
                    clk_count_s = 16'd0;
                    if (rx_s == 1'b1) begin
                        valid_s = 1'b1;
`ifdef UART_RX_PARITY_EN
                        perr_s  = parity_fail(shift_r, parity_bit_r);
`endif
                        state_s = IDLE;
                    end else begin
                        ferr_s  = 1'b1;
                        state_s = BREAK;
                    end
                end else begin
                    clk_count_s = clk_count_r + 16'd1;
                end
            end
            BREAK: begin
                // Held-low line: wait it out so it cannot look like new frames.
                clk_count_s = 16'd0;
                if (rx_s == 1'b1) begin
                    state_s = IDLE;
                end else begin
                    state_s = BREAK;
                end
            end
            default: begin
                state_s     = IDLE;
                clk_count_s = 16'd0;
                bit_index_s = 3'd0;
            end
        endcase
    end

    // FSM state, counters and shift register.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_r     <= IDLE;
            clk_count_r <= 16'd0;
            bit_index_r <= 3'd0;
            shift_r     <= 8'h00;
`ifdef UART_RX_PARITY_EN
            parity_bit_r <= 1'b0;
`endif
        end else begin
            state_r     <= state_s;
            clk_count_r <= clk_count_s;
            bit_index_r <= bit_index_s;
            shift_r     <= shift_s;
`ifdef UART_RX_PARITY_EN
            parity_bit_r <= parity_bit_s;
`endif
        end
    end

    // Registered outputs; busy follows the state register one cycle later so
    // it drops the cycle after the rx_valid strobe.
    always_ff @(posedge clk) begin
        if (!rst) begin
            rx_data_r   <= 8'h00;
            rx_valid_r  <= 1'b0;
            frame_err_r <= 1'b0;
            busy_r      <= 1'b0;
`ifdef UART_RX_PARITY_EN
            parity_err_r <= 1'b0;
`endif
        end else begin
            rx_valid_r  <= valid_s;
            frame_err_r <= ferr_s;
            busy_r      <= (state_r != IDLE);
            if (valid_s) begin
                rx_data_r <= shift_r;
            end
`ifdef UART_RX_PARITY_EN
            parity_err_r <= perr_s;
`endif
        end
    end

    assign bus.rx_data   = rx_data_r;
    assign bus.rx_valid  = rx_valid_r;
    assign bus.frame_err = frame_err_r;
    assign bus.busy      = busy_r;
`ifdef UART_RX_PARITY_EN
    assign bus.parity_err = parity_err_r;
`endif

endmodule

// File: tb/tb_uart_rx.sv
// tb_uart_rx: self-checking bench for uart_rx.
// The bench drives serial frames bit by bit; for every frame it launches it
// records the expected outcome (byte or framing error) and the cycle at which
// the strobe must appear, computed from the frame start time. A compare
// process checks the outputs against that expectation list every cycle.
module tb_uart_rx;
    localparam int CLK_FREQ  = 125000000;
    localparam int BAUD_RATE = 115200;
    localparam int BIT       = CLK_FREQ / BAUD_RATE;
    localparam int HALF      = BIT / 2;
`ifdef UART_RX_PARITY_EN
    localparam int PBITS     = 1;
    localparam int LAT_LIT   = 11395;
    localparam int FRAME_LIT = 11935;
`else
    localparam int PBITS     = 0;
    localparam int LAT_LIT   = 10310;
    localparam int FRAME_LIT = 10850;
`endif
    // Start edge -> strobe: 2 sync clocks, half bit, 8 data (+parity) + stop, 1 output register.
    localparam int LAT = 2 + HALF + (9 + PBITS) * BIT + 1;

    typedef struct {
        int         t;
        bit         ok;
        logic [7:0] data;
        bit         perr;
    } ev_t;

    logic clk = 1'b0;
    logic rst = 1'b0;
    int   cyc = 0;
    int   n_chk = 0;
    int   n_pass = 0;
    int   fe_count = 0;
    logic [7:0] m_data = 8'h00;
    bit   prev_valid = 1'b0;
    ev_t  exp_q[$];
    int   valid_times[$];

    uart_rx_if bus();

    uart_rx #(.CLK_FREQ(CLK_FREQ), .BAUD_RATE(BAUD_RATE)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #4 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Drive the line to v for n clocks; returns #1 after a rising edge.
    task automatic hold(input logic v, input int n);
        bus.rx = v;
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [7:0] d, input bit stop, input bit bad_par, output int k);
        ev_t e;
        k = cyc;
        e.t = k + LAT;
        e.ok = stop;
        e.data = d;
        e.perr = bad_par;
        exp_q.push_back(e);
        hold(1'b0, BIT);
        for (int i = 0; i < 8; i++) hold(d[i], BIT);
`ifdef UART_RX_PARITY_EN
        hold((^d) ^ bad_par, BIT);
`endif
        hold(stop, BIT);
    endtask

    // Compare process: every strobe must match the next expected event within
    // one clock; rx_data must always equal the last expected good byte.
    initial begin
        ev_t  ev;
        logic exp_perr;
        forever begin
            @(negedge clk);
            exp_perr = 1'b0;
            if (!rst) begin
                exp_q.delete();
                m_data = 8'h00;
                prev_valid = 1'b0;
            end else begin
                if (bus.rx_valid || bus.frame_err) begin
                    if (exp_q.size() > 0 && cyc >= exp_q[0].t - 1 && cyc <= exp_q[0].t + 1) begin
                        ev = exp_q.pop_front();
                        check("pulse_kind", 32'({bus.rx_valid, bus.frame_err}), ev.ok ? 32'd2 : 32'd1);
                        check("busy_at_pulse", 32'(bus.busy), 32'd1);
                        if (ev.ok) begin
                            m_data = ev.data;
                            valid_times.push_back(cyc);
                            exp_perr = ev.perr;
                        end else begin
                            fe_count++;
                        end
                    end else begin
                        check("unexpected_pulse", 32'({bus.rx_valid, bus.frame_err}), 32'd0);
                        if (bus.frame_err) fe_count++;
                    end
                end else if (exp_q.size() > 0 && cyc > exp_q[0].t + 1) begin
                    ev = exp_q.pop_front();
                    check("missed_pulse", 32'({bus.rx_valid, bus.frame_err}), ev.ok ? 32'd2 : 32'd1);
                end
                check("rx_data", 32'(bus.rx_data), 32'(m_data));
                if (prev_valid) check("busy_after_valid", 32'(bus.busy), 32'd0);
`ifdef UART_RX_PARITY_EN
                check("parity_err", 32'(bus.parity_err), 32'(exp_perr));
`endif
                prev_valid = bus.rx_valid;
            end
        end
    end

    initial begin
        repeat (200000) @(posedge clk);
        $display("FAIL watchdog: cycle budget exhausted at %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        int k;
        int k2;
        int n0;
        int dl;
        logic [7:0] b;

        // Reset
        bus.rx = 1'b1;
        rst = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b1;
        @(negedge clk);
        check("reset_rx_valid", 32'(bus.rx_valid), 32'd0);
        check("reset_frame_err", 32'(bus.frame_err), 32'd0);
        check("reset_busy", 32'(bus.busy), 32'd0);
        check("reset_rx_data", 32'(bus.rx_data), 32'h00);
        @(posedge clk);
        #1;
        hold(1'b1, 10);

        // Single frame 0x35 and its latency
        send(8'h35, 1'b1, 1'b0, k);
        hold(1'b1, 20);
        check("t1_data", 32'(bus.rx_data), 32'h35);
        check("t1_valid_count", 32'(valid_times.size()), 32'd1);
        dl = (valid_times.size() > 0) ? valid_times[0] - k : -1000;
        check("t1_latency", 32'(dl >= LAT_LIT - 1 && dl <= LAT_LIT + 1), 32'd1);

        // 300-clock glitch: busy for about half a bit, then nothing
        k = cyc;
        hold(1'b0, 300);
        check("glitch_busy_high", 32'(bus.busy), 32'd1);
        hold(1'b1, HALF - 300 + 10);
        check("glitch_busy_low", 32'(bus.busy), 32'd0);
        check("glitch_no_valid", 32'(valid_times.size()), 32'd1);
        check("glitch_no_ferr", 32'(fe_count), 32'd0);
        hold(1'b1, 20);

        // Framing error followed by a long break
        send(8'hA5, 1'b0, 1'b0, k);
        hold(1'b0, 5000);
        check("break_busy_high", 32'(bus.busy), 32'd1);
        check("break_one_ferr", 32'(fe_count), 32'd1);
        check("break_data_kept", 32'(bus.rx_data), 32'h35);
        hold(1'b1, 10);
        check("break_busy_low", 32'(bus.busy), 32'd0);
        hold(1'b1, 20);
        check("break_no_valid", 32'(valid_times.size()), 32'd1);

        // Back-to-back 0x00 / 0xFF with no idle gap
        n0 = valid_times.size();
        send(8'h00, 1'b1, 1'b0, k);
        send(8'hFF, 1'b1, 1'b0, k2);
        hold(1'b1, 20);
        check("b2b_count", 32'(valid_times.size()), 32'(n0 + 2));
        dl = (valid_times.size() >= n0 + 2) ? valid_times[n0 + 1] - valid_times[n0] : -1000;
        check("b2b_spacing", 32'(dl >= FRAME_LIT - 1 && dl <= FRAME_LIT + 1), 32'd1);
        check("b2b_data", 32'(bus.rx_data), 32'hFF);

        // Reset pulse in the middle of data bit 4 (bit 4 is high there)
        b = 8'($urandom) | 8'h10;
        hold(1'b0, BIT);
        for (int i = 0; i < 4; i++) hold(b[i], BIT);
        hold(1'b1, BIT / 2);
        rst = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b1;
        @(negedge clk);
        check("midrst_rx_valid", 32'(bus.rx_valid), 32'd0);
        check("midrst_frame_err", 32'(bus.frame_err), 32'd0);
        check("midrst_busy", 32'(bus.busy), 32'd0);
        check("midrst_rx_data", 32'(bus.rx_data), 32'h00);
        @(posedge clk);
        #1;
        hold(1'b1, 20 + int'($urandom_range(0, 30)));
        send(8'h5A, 1'b1, 1'b0, k);
        hold(1'b1, 20);
        check("after_rst_data", 32'(bus.rx_data), 32'h5A);

        // Random byte after a random idle gap
        b = 8'($urandom);
        hold(1'b1, int'($urandom_range(0, 40)));
        send(b, 1'b1, 1'b0, k);
        hold(1'b1, 20);
        check("random_data", 32'(bus.rx_data), 32'(b));

`ifdef UART_RX_PARITY_EN
        send(8'h07, 1'b1, 1'b0, k);
        send(8'h07, 1'b1, 1'b1, k);
        hold(1'b1, 20);
        check("parity_data", 32'(bus.rx_data), 32'h07);
`endif

        hold(1'b1, 10);
        check("all_events_seen", 32'(exp_q.size()), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
